// File: rtl/round_timer_controller_if.sv
// round_timer_controller_if: player controls in, time/status display out
interface round_timer_controller_if;
  logic        start;
  logic        pause_toggle;
  logic        add_bonus;
  logic        round_clear;
  logic [15:0] time_display;
  logic        run_out;
  logic        win;
  logic        running;
  logic [3:0]  round_num;
  logic [2:0]  state_out;
  modport master (
    output start, pause_toggle, add_bonus, round_clear,
    input  time_display, run_out, win, running, round_num, state_out
  );
  modport slave (
    input  start, pause_toggle, add_bonus, round_clear,
    output time_display, run_out, win, running, round_num, state_out
  );
endinterface

// File: rtl/round_timer_controller.sv
// round_timer_controller: game-round BCD countdown with pause, bonus, rounds, timeout and win
module round_timer_controller #(
  parameter int          TICK_CYCLES = 50000000,
  parameter logic [15:0] ROUND_SECS  = 16'h0060,
  parameter logic [15:0] BONUS_SECS  = 16'h0010,
  parameter int          NUM_ROUNDS  = 3
) (
  input logic Clk,
  input logic Reset,
  round_timer_controller_if.slave bus
);
  localparam int PW = $clog2(TICK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, PAUSE = 3'd2, ROUND_DONE = 3'd3, TIMEOUT = 3'd4, WIN = 3'd5} state_t;
  state_t state, state_n;
  logic [15:0] secs, secs_n, dec_v, upd_v;
  logic [PW-1:0] pre, pre_n;
  logic [3:0] round, round_n;
  logic start_q, pause_q, start_rise, pause_rise, tick;
  logic run_out_q, win_q, running_q;
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic b;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r[i*4+:4] = (b && v[i*4+:4] == 4'd0) ? 4'd9 : v[i*4+:4] - {3'd0, b};
      b = b && v[i*4+:4] == 4'd0;
    end
    return r;
  endfunction
  // a carry out of the thousands digit means the sum passed 9999
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [4:0] s;
    logic c;
    c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = {1'b0, a[i*4+:4]} + {1'b0, b[i*4+:4]} + {4'd0, c};
      c = s > 5'd9;
      r[i*4+:4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return c ? 16'h9999 : r;
  endfunction
  always_comb begin
    start_rise = bus.start & ~start_q;
    pause_rise = bus.pause_toggle & ~pause_q;
    tick = state == RUN && pre == PW'(TICK_CYCLES - 1);
    dec_v = tick ? bcd_dec(secs) : secs;
    upd_v = bus.add_bonus ? bcd_add_sat(dec_v, BONUS_SECS) : dec_v;
    state_n = state;
    secs_n = secs;
    pre_n = pre;
    round_n = round;
    case (state)
      IDLE: begin
        secs_n = ROUND_SECS;
        round_n = 4'd0;
        if (start_rise) begin
          state_n = RUN;
          round_n = 4'd1;
          pre_n = '0;
        end
      end
      RUN: begin
        pre_n = tick ? '0 : pre + PW'(1);
        if (bus.round_clear) state_n = ROUND_DONE;
        else if (tick && secs == 16'h0000) state_n = TIMEOUT;
        else begin
          secs_n = upd_v;
          state_n = pause_rise ? PAUSE : RUN;
        end
      end
      PAUSE: begin
        secs_n = upd_v;
        state_n = pause_rise ? RUN : PAUSE;
      end
      ROUND_DONE: begin
        if (round == 4'(NUM_ROUNDS)) state_n = WIN;
        else begin
          state_n = RUN;
          round_n = round + 4'd1;
          secs_n = ROUND_SECS;
          pre_n = '0;
        end
      end
      TIMEOUT, WIN: begin
        if (state == TIMEOUT) secs_n = 16'h0000;
        if (start_rise) begin
          state_n = IDLE;
          secs_n = ROUND_SECS;
          round_n = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      secs <= ROUND_SECS;
      pre <= '0;
      round <= 4'd0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      run_out_q <= 1'b0;
      win_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state <= state_n;
      secs <= secs_n;
      pre <= pre_n;
      round <= round_n;
      start_q <= bus.start;
      pause_q <= bus.pause_toggle;
      run_out_q <= state_n == TIMEOUT;
      win_q <= state_n == WIN;
      running_q <= state_n == RUN;
    end
  end
  assign bus.time_display = secs;
  assign bus.run_out = run_out_q;
  assign bus.win = win_q;
  assign bus.running = running_q;
  assign bus.round_num = round;
  assign bus.state_out = state;
endmodule
